ase_rsp_scoreboard: RTL and testbench
=====================================

# ase_rsp_scoreboard

- Response-direction latency model for ASE.
- Accepts response records (RX header + data) from the ASE stubs, holds each for a per-record delay, then issues them to the AFU on a CCI RX channel as single-cycle valid strobes.
- Optionally reorders responses, as the host does.
- Sits between the DPI response path and the CCI RX port: the counterpart of the request-side latency buffer.

## Interface
- NUM_SLOTS, 16: response slots held; power of two, 2..128.
- HDR_WIDTH, 18: RX header width.
- DATA_WIDTH, 512: payload width.
- COUNT_WIDTH, 8: delay counter width.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- meta_in  in  HDR_WIDTH  response header from stubs.
- data_in  in  DATA_WIDTH  response payload.
- delay_in  in  COUNT_WIDTH  hold time in cycles, sampled with write_en.
- write_en  in  1  push one response.
- out_stall  in  1  RX channel busy; no issue this cycle.
- meta_out  out  HDR_WIDTH  issued header, registered.
- data_out  out  DATA_WIDTH  issued payload, registered.
- valid_out  out  1  one-cycle strobe per response; AFU cannot backpressure.
- count  out  $clog2(NUM_SLOTS+1)  occupied slots.
- empty  out  1  count==0.
- full  out  1  count==NUM_SLOTS.
- overflow  out  1  one-cycle pulse: write_en while full.

## Operation
- Per-slot state: SLOT_FREE -> SLOT_COUNTDOWN (on accept) -> SLOT_READY (ctr==0) -> SLOT_FREE (on issue).
- Accept: write_en && !full allocates the lowest-index FREE slot and loads ctr=delay_in; meta and data are stored. delay_in==0 enters SLOT_READY directly.
- Countdown: every cycle a COUNTDOWN slot decrements ctr, and moves to READY at 0. out_stall does not freeze counters.
- Issue: in a cycle with !out_stall, at most one READY slot is selected. Its record is registered onto meta_out/data_out with valid_out=1 the next cycle; the slot is freed at the same edge.
- Selection: round-robin scan starting at last_issued+1 mod NUM_SLOTS.
- full and empty are derived from the registered count; count is +1 per accept and -1 per issue.
- Write while full: the record is dropped and overflow pulses, even if an issue frees a slot that same cycle.
- A slot freed at edge N is allocatable from cycle N onward.
- meta_out/data_out hold their last value when valid_out=0.

## Timing
- Reset values: valid_out=0, meta_out=0, data_out=0, count=0, empty=1, full=0, overflow=0; all slots FREE; last_issued=NUM_SLOTS-1.
- Latency: a write in cycle T with delay D, no contention and no stall, gives valid_out in cycle T+D+2. Minimum is 2.
- Contention or stall adds whole cycles only; no response is ever lost or duplicated.
- Reset mid-operation: all in-flight records are discarded. No valid_out occurs in the cycle after rst and thereafter until a new write arrives.

## Configuration
- ASE_RSP_REORDER_EN defined: round-robin selection among READY slots, so responses may leave out of arrival order.
- ASE_RSP_REORDER_EN undefined: strict arrival order. Only the oldest occupied slot may issue, and only once READY. Younger READY slots wait; their counters stay at 0.

## Structure
- ase_rsp_sb_pkg holds:
  - slot_state_e (SLOT_FREE, SLOT_COUNTDOWN, SLOT_READY);
  - the rsp_slot_t packed struct (meta, data, ctr, state);
  - the LAT_MIN_CYCLES=2 constant.
- Sub-module ase_rsp_order_fifo: a slot-index FIFO of depth NUM_SLOTS giving the oldest slot. It is instantiated only when ASE_RSP_REORDER_EN is undefined.

## Test plan
- Reset, then write meta=0x1A5, D=3 at cycle 10 -> valid_out only in cycle 15 with meta_out=0x1A5; count returns to 0 and empty=1.
- Write A (D=10) at cycle 0 and B (D=1) at cycle 1:
  - with the macro, B issues at cycle 4 and A at cycle 12;
  - without it, A issues at 12 and B at 13.
- 16 writes with D=50 -> full=1 after the 16th; a 17th write -> overflow high for exactly one cycle, record dropped; exactly 16 valid_out strobes follow.
- Write slot0 with D=5 at cycle 0 and slot1 with D=4 at cycle 1 (both READY together) -> slot0 issues at cycle 7, slot1 at cycle 8.
- Repeat the previous case with out_stall=1 in cycles 6-8 -> slot0 issues at 10, slot1 at 11.
- Four records in flight, rst high in cycle 5 -> no valid_out afterward; count=0, empty=1 from cycle 6.

Source files
------------

// File: rtl/ase_rsp_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ase_rsp_sb_pkg
// Purpose  : Shared types and constants for the ASE response-direction
//            latency scoreboard (slot state encoding, slot record layout,
//            minimum response latency).
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package ase_rsp_sb_pkg;

    // Record field widths; the scoreboard parameters default to these and
    // the slot record is laid out with them.
    localparam int RSP_HDR_WIDTH   = 18;
    localparam int RSP_DATA_WIDTH  = 512;
    localparam int RSP_COUNT_WIDTH = 8;

    // Fewest cycles from write_en to valid_out (delay_in == 0).
    localparam int LAT_MIN_CYCLES  = 2;

    typedef enum logic [1:0] {
        SLOT_FREE      = 2'd0,
        SLOT_COUNTDOWN = 2'd1,
        SLOT_READY     = 2'd2
    } slot_state_e;

    typedef struct packed {
        logic [RSP_HDR_WIDTH-1:0]   meta;
        logic [RSP_DATA_WIDTH-1:0]  data;
        logic [RSP_COUNT_WIDTH-1:0] ctr;
        slot_state_e                state;
    } rsp_slot_t;

endpackage : ase_rsp_sb_pkg
`default_nettype wire

// File: rtl/ase_rsp_order_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ase_rsp_order_fifo
// Purpose  : FIFO of slot indices in arrival order. The head is the oldest
//            occupied scoreboard slot; used for strict in-order issue.
// Ports    : clk, rst        clock, synchronous active-high reset
//            push, push_idx  append the slot index just allocated
//            pop             remove the head (head slot was issued)
//            head_idx        oldest occupied slot index
//            head_valid      FIFO holds at least one index
// Revision : 1.0  initial release
// ============================================================================
module ase_rsp_order_fifo
    import ase_rsp_sb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [$clog2(DEPTH)-1:0] push_idx,
    input  logic                     pop,
    output logic [$clog2(DEPTH)-1:0] head_idx,
    output logic                     head_valid
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] C_DEPTH = (IDX_W+1)'(DEPTH);

    logic [IDX_W-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0] r_rd_ptr;
    logic [IDX_W-1:0] r_wr_ptr;
    logic [IDX_W:0]   r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok  = push && (r_level != C_DEPTH);
    assign w_pop_ok   = pop && (r_level != '0);
    assign head_idx   = r_mem[r_rd_ptr];
    assign head_valid = (r_level != '0);

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin : p_fifo
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= push_idx;
                r_wr_ptr        <= r_wr_ptr + IDX_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + IDX_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + (IDX_W+1)'(1);
                2'b01:   r_level <= r_level - (IDX_W+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule : ase_rsp_order_fifo
`default_nettype wire

// File: rtl/ase_rsp_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : ase_rsp_scoreboard
// Purpose  : Response-direction latency model for ASE. Holds each response
//            record for its own delay, then issues it to the AFU as a
//            one-cycle valid strobe on the CCI RX channel.
// Config   : ASE_RSP_REORDER_EN defined   -> round-robin issue among READY
//                                            slots (out-of-order responses)
//            ASE_RSP_REORDER_EN undefined -> strict arrival order
// Ports    : clk, rst                     clock, sync active-high reset
//            meta_in, data_in, delay_in   response record and hold time
//            write_en                     push one response
//            out_stall                    RX channel busy, no issue
//            meta_out, data_out, valid_out  registered issued response
//            count, empty, full           slot occupancy
//            overflow                     pulse after a write while full
// Revision : 1.0  initial release
// ============================================================================
module ase_rsp_scoreboard
    import ase_rsp_sb_pkg::*;
#(
    parameter int NUM_SLOTS   = 16,
    parameter int HDR_WIDTH   = RSP_HDR_WIDTH,
    parameter int DATA_WIDTH  = RSP_DATA_WIDTH,
    parameter int COUNT_WIDTH = RSP_COUNT_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [HDR_WIDTH-1:0]             meta_in,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic [COUNT_WIDTH-1:0]           delay_in,
    input  logic                             write_en,
    input  logic                             out_stall,
    output logic [HDR_WIDTH-1:0]             meta_out,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             valid_out,
    output logic [$clog2(NUM_SLOTS+1)-1:0]   count,
    output logic                             empty,
    output logic                             full,
    output logic                             overflow
);
    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam int CNT_W = $clog2(NUM_SLOTS+1);
    localparam logic [CNT_W-1:0]           C_FULL_COUNT = CNT_W'(NUM_SLOTS);
    localparam logic [RSP_COUNT_WIDTH-1:0] C_CTR_ONE    = RSP_COUNT_WIDTH'(1);

    rsp_slot_t        r_slots [NUM_SLOTS];
    logic [IDX_W-1:0] w_alloc_idx;
    logic             w_alloc_found;
    logic             w_accept;
    logic             w_issue;
    logic [IDX_W-1:0] w_sel_idx;

    // Occupancy flags come from the registered count, so a slot freed by an
    // issue in this cycle does not rescue a write that sees full.
    assign empty    = (count == '0);
    assign full     = (count == C_FULL_COUNT);
    assign w_accept = write_en && !full;

    // Lowest-index FREE slot. When !full a free slot always exists because
    // count tracks exactly the non-FREE slots.
    always_comb begin : p_alloc
        w_alloc_idx   = '0;
        w_alloc_found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!w_alloc_found && (r_slots[i].state == SLOT_FREE)) begin
                w_alloc_idx   = IDX_W'(i);
                w_alloc_found = 1'b1;
            end
        end
    end

`ifdef ASE_RSP_REORDER_EN
    logic [IDX_W-1:0] r_last_issued;

    // Round-robin: scan from last_issued+1, wrapping modulo NUM_SLOTS.
    always_comb begin : p_select
        w_issue   = 1'b0;
        w_sel_idx = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (!w_issue && !out_stall &&
                (r_slots[r_last_issued + IDX_W'(k + 1)].state == SLOT_READY)) begin
                w_issue   = 1'b1;
                w_sel_idx = r_last_issued + IDX_W'(k + 1);
            end
        end
    end

    always_ff @(posedge clk) begin : p_last_issued
        if (rst) begin
            r_last_issued <= IDX_W'(NUM_SLOTS - 1);
        end else if (w_issue) begin
            r_last_issued <= w_sel_idx;
        end
    end
`else
    logic [IDX_W-1:0] w_oldest_idx;
    logic             w_oldest_valid;

    ase_rsp_order_fifo #(
        .DEPTH      (NUM_SLOTS)
    ) u_order_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_accept),
        .push_idx   (w_alloc_idx),
        .pop        (w_issue),
        .head_idx   (w_oldest_idx),
        .head_valid (w_oldest_valid)
    );

    // Only the oldest occupied slot may go; younger READY slots simply wait.
    always_comb begin : p_select
        w_sel_idx = w_oldest_idx;
        w_issue   = w_oldest_valid && !out_stall &&
                    (r_slots[w_oldest_idx].state == SLOT_READY);
    end
`endif

    // Per-slot lifecycle. A COUNTDOWN slot with ctr==1 reaches 0 on this edge
    // and is READY next cycle; counters keep running during out_stall.
    always_ff @(posedge clk) begin : p_slots
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_slots[i].state <= SLOT_FREE;
                r_slots[i].ctr   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                case (r_slots[i].state)
                    SLOT_FREE: begin
                        if (w_accept && (w_alloc_idx == IDX_W'(i))) begin
                            r_slots[i].meta  <= meta_in;
                            r_slots[i].data  <= data_in;
                            r_slots[i].ctr   <= delay_in;
                            r_slots[i].state <= (delay_in == '0) ? SLOT_READY
                                                                 : SLOT_COUNTDOWN;
                        end
                    end
                    SLOT_COUNTDOWN: begin
                        if (r_slots[i].ctr <= C_CTR_ONE) begin
                            r_slots[i].ctr   <= '0;
                            r_slots[i].state <= SLOT_READY;
                        end else begin
                            r_slots[i].ctr   <= r_slots[i].ctr - C_CTR_ONE;
                        end
                    end
                    SLOT_READY: begin
                        if (w_issue && (w_sel_idx == IDX_W'(i))) begin
                            r_slots[i].state <= SLOT_FREE;
                        end
                    end
                    default: begin
                        r_slots[i].state <= SLOT_FREE;
                    end
                endcase
            end
        end
    end

    // Registered RX-side outputs and occupancy counter.
    always_ff @(posedge clk) begin : p_outputs
        if (rst) begin
            valid_out <= 1'b0;
            meta_out  <= '0;
            data_out  <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            valid_out <= w_issue;
            overflow  <= write_en && full;
            if (w_issue) begin
                meta_out <= r_slots[w_sel_idx].meta;
                data_out <= r_slots[w_sel_idx].data;
            end
            case ({w_accept, w_issue})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : ase_rsp_scoreboard
`default_nettype wire

// File: tb/tb_ase_rsp_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_ase_rsp_scoreboard
// Purpose  : Self-checking bench for ase_rsp_scoreboard. A transaction-level
//            reference model (records with absolute ready cycles) predicts
//            every output each cycle; a latency table and scenario sequences
//            check specific issue cycles. Honours ASE_RSP_REORDER_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_ase_rsp_scoreboard;
    localparam int N  = 16;
    localparam int HW = 18;
    localparam int DW = 512;
    localparam int CW = 8;
    localparam int NW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [HW-1:0] meta_in;
    logic [DW-1:0] data_in;
    logic [CW-1:0] delay_in;
    logic          write_en;
    logic          out_stall;
    logic [HW-1:0] meta_out;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [NW-1:0] count;
    logic          empty;
    logic          full;
    logic          overflow;

    ase_rsp_scoreboard #(
        .NUM_SLOTS   (N),
        .HDR_WIDTH   (HW),
        .DATA_WIDTH  (DW),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .meta_in   (meta_in),
        .data_in   (data_in),
        .delay_in  (delay_in),
        .write_en  (write_en),
        .out_stall (out_stall),
        .meta_out  (meta_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int            c;
        logic [HW-1:0] m;
    } ev_t;
    ev_t log_q[$];

    // Reference model: set of held records, each with the first cycle in
    // which it may be selected (accept cycle + 1 + delay).
    bit            m_busy  [N];
    int            m_ready [N];
    int            m_seq   [N];
    logic [HW-1:0] m_meta  [N];
    logic [DW-1:0] m_data  [N];
    int            m_cnt;
    int            m_last;
    int            m_seq_next;
    logic          e_valid;
    logic          e_ovf;
    logic [HW-1:0] e_meta;
    logic [DW-1:0] e_data;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < N; s++) m_busy[s] = 1'b0;
        m_cnt   = 0;
        m_last  = N - 1;
        e_valid = 1'b0;
        e_ovf   = 1'b0;
        e_meta  = '0;
        e_data  = '0;
    endtask

    task automatic model_step(input logic w, input logic [HW-1:0] m, input logic [DW-1:0] d,
                              input logic [CW-1:0] dl, input logic st, input logic r);
        int sel    = -1;
        int a      = -1;
        int oldest = -1;
        bit full_now;
        if (r) begin
            model_reset();
            return;
        end
        full_now = (m_cnt == N);
        if (!st) begin
`ifdef ASE_RSP_REORDER_EN
            for (int k = 1; k <= N; k++) begin
                int s;
                s = (m_last + k) % N;
                if (sel < 0 && m_busy[s] && m_ready[s] <= cyc) sel = s;
            end
`else
            for (int s = 0; s < N; s++)
                if (m_busy[s] && (oldest < 0 || m_seq[s] < m_seq[oldest])) oldest = s;
            if (oldest >= 0 && m_ready[oldest] <= cyc) sel = oldest;
`endif
        end
        if (w && !full_now)
            for (int s = 0; s < N; s++)
                if (a < 0 && !m_busy[s]) a = s;
        e_ovf   = w && full_now;
        e_valid = (sel >= 0);
        if (sel >= 0) begin
            e_meta       = m_meta[sel];
            e_data       = m_data[sel];
            m_busy[sel]  = 1'b0;
            m_last       = sel;
            m_cnt--;
        end
        if (a >= 0) begin
            m_busy[a]  = 1'b1;
            m_ready[a] = cyc + 1 + int'(dl);
            m_seq[a]   = m_seq_next++;
            m_meta[a]  = m;
            m_data[a]  = d;
            m_cnt++;
        end
    endtask

    // One clock cycle: drive inputs, advance, compare every output to model.
    task automatic step(input logic w, input logic [HW-1:0] m, input logic [CW-1:0] dl,
                        input logic st, input logic r);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        write_en  = w;
        meta_in   = m;
        data_in   = d;
        delay_in  = dl;
        out_stall = st;
        rst       = r;
        model_step(w, m, d, dl, st, r);
        @(posedge clk);
        #1;
        cyc++;
        if (valid_out === 1'b1) log_q.push_back('{cyc, meta_out});
        chk("valid_out", DW'(valid_out), DW'(e_valid));
        chk("meta_out",  DW'(meta_out),  DW'(e_meta));
        chk("data_out",  data_out,       e_data);
        chk("count",     DW'(count),     DW'(m_cnt));
        chk("empty",     DW'(empty),     DW'(m_cnt == 0));
        chk("full",      DW'(full),      DW'(m_cnt == N));
        chk("overflow",  DW'(overflow),  DW'(e_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, '0, '0, 1'b0, 1'b1);
        log_q.delete();
    endtask

    task automatic chk_ev(input string name, input int idx, input int exp_c, input logic [HW-1:0] exp_m);
        if (log_q.size() > idx) begin
            chk({name, "_cycle"}, DW'(log_q[idx].c), DW'(exp_c));
            chk({name, "_meta"},  DW'(log_q[idx].m), DW'(exp_m));
        end else begin
            chk({name, "_present"}, DW'(log_q.size()), DW'(idx + 1));
        end
    endtask

    typedef struct {
        logic [CW-1:0] dly;
        logic [HW-1:0] meta;
        int            lat;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   t0;
        int   wprob;
        vecs[0] = '{8'd0,   18'h00011, 2};
        vecs[1] = '{8'd1,   18'h00122, 3};
        vecs[2] = '{8'd2,   18'h01233, 4};
        vecs[3] = '{8'd7,   18'h12344, 9};
        vecs[4] = '{8'd31,  18'h23455, 33};
        vecs[5] = '{8'd255, 18'h3ABCD, 257};
        m_seq_next = 0;
        write_en = 0; out_stall = 0; rst = 1; meta_in = '0; data_in = '0; delay_in = '0;
        model_reset();

        // Reset state
        do_reset();
        do_reset();
        chk("reset_valid", DW'(valid_out), '0);
        chk("reset_empty", DW'(empty), DW'(1));
        chk("reset_count", DW'(count), '0);

        // Latency table: single write, issue exactly D+2 cycles later
        foreach (vecs[v]) begin
            do_reset();
            t0 = cyc;
            step(1'b1, vecs[v].meta, vecs[v].dly, 1'b0, 1'b0);
            idle(vecs[v].lat + 2);
            chk("vec_strobes", DW'(log_q.size()), DW'(1));
            chk_ev("vec", 0, t0 + vecs[v].lat, vecs[v].meta);
        end

        // Basic: meta 0x1A5, D=3
        do_reset();
        idle(2);
        t0 = cyc;
        step(1'b1, 18'h1A5, 8'd3, 1'b0, 1'b0);
        idle(8);
        chk("basic_strobes", DW'(log_q.size()), DW'(1));
        chk_ev("basic", 0, t0 + 5, 18'h1A5);
        chk("basic_count", DW'(count), '0);
        chk("basic_empty", DW'(empty), DW'(1));

        // A (D=10) then B (D=1)
        do_reset();
        t0 = cyc;
        step(1'b1, 18'h2AAAA, 8'd10, 1'b0, 1'b0);
        step(1'b1, 18'h0BBBB, 8'd1,  1'b0, 1'b0);
        idle(16);
        chk("ab_strobes", DW'(log_q.size()), DW'(2));
`ifdef ASE_RSP_REORDER_EN
        chk_ev("ab_first",  0, t0 + 4,  18'h0BBBB);
        chk_ev("ab_second", 1, t0 + 12, 18'h2AAAA);
`else
        chk_ev("ab_first",  0, t0 + 12, 18'h2AAAA);
        chk_ev("ab_second", 1, t0 + 13, 18'h0BBBB);
`endif

        // Fill to full, then one overflowing write
        do_reset();
        for (int i = 0; i < N; i++) step(1'b1, HW'(i + 16'h100), 8'd50, 1'b0, 1'b0);
        chk("fill_full", DW'(full), DW'(1));
        step(1'b1, 18'h3FFFF, 8'd50, 1'b0, 1'b0);
        chk("ovf_pulse", DW'(overflow), DW'(1));
        idle(1);
        chk("ovf_single", DW'(overflow), '0);
        idle(70);
        chk("fill_strobes", DW'(log_q.size()), DW'(N));
        foreach (log_q[i]) chk("fill_no_dropped", DW'(log_q[i].m == 18'h3FFFF), '0);

        // Two slots READY in the same cycle
        do_reset();
        t0 = cyc;
        step(1'b1, 18'h000C0, 8'd5, 1'b0, 1'b0);
        step(1'b1, 18'h000C1, 8'd4, 1'b0, 1'b0);
        idle(10);
        chk_ev("tie_s0", 0, t0 + 7, 18'h000C0);
        chk_ev("tie_s1", 1, t0 + 8, 18'h000C1);

        // Same, with out_stall in cycles 6..8
        do_reset();
        t0 = cyc;
        step(1'b1, 18'h000D0, 8'd5, 1'b0, 1'b0);
        step(1'b1, 18'h000D1, 8'd4, 1'b0, 1'b0);
        for (int c = 2; c < 14; c++) step(1'b0, '0, '0, (c >= 6 && c <= 8), 1'b0);
        chk_ev("stall_s0", 0, t0 + 10, 18'h000D0);
        chk_ev("stall_s1", 1, t0 + 11, 18'h000D1);

        // Reset with four records in flight
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, HW'(i + 18'h200), 8'd20, 1'b0, 1'b0);
        idle(1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("rst_count", DW'(count), '0);
        chk("rst_empty", DW'(empty), DW'(1));
        idle(30);
        chk("rst_no_strobes", DW'(log_q.size()), '0);

        // Randomised traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            wprob = ((i / 200) % 2 == 1) ? 90 : 35;
            step($urandom_range(0, 99) < wprob,
                 HW'($urandom),
                 ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 60)) : CW'($urandom_range(0, 8)),
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 599) == 0);
        end
        idle(80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ase_rsp_scoreboard
`default_nettype wire
